// File: rtl/mem_access_ctrl.sv
// Load/store access controller: turns one byte/halfword/word request into
// memory read and/or write cycles. Sub-word stores are done as
// read-modify-write on a 32-bit little-endian word memory.
module mem_access_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic        wr,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] rdata,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wd,
  output logic        mem_we,
  input  logic [31:0] mem_rd
);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_DONE} state_t;

  state_t      state_q, state_d;
  logic [31:0] addr_q, wdata_q, buf_q, rdata_q;
  logic [1:0]  size_q;
  logic        wr_q, sext_q, err_q;
  logic        misalign;
  logic        accept;
  logic [7:0]  ld_b;
  logic [15:0] ld_h;
  logic [31:0] load_val;

  assign misalign = (size == 2'b11)
                  | ((size == 2'b01) & addr[0])
                  | ((size == 2'b10) & (addr[1:0] != 2'b00));
  assign accept   = (state_q == S_IDLE) & req;

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          if (misalign)              state_d = S_DONE;
          else if (!wr)              state_d = S_READ;
          else if (size == 2'b10)    state_d = S_WRITE;
          else                       state_d = S_READ;
        end
      end
      S_READ:  state_d = wr_q ? S_WRITE : S_DONE;
      S_WRITE: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Request latch; only the latched copies steer the rest of the access
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q  <= '0;
      wdata_q <= '0;
      size_q  <= '0;
      wr_q    <= 1'b0;
      sext_q  <= 1'b0;
      err_q   <= 1'b0;
    end else if (accept) begin
      addr_q  <= addr;
      wdata_q <= wdata;
      size_q  <= size;
      wr_q    <= wr;
      sext_q  <= sign_ext;
      err_q   <= misalign;
    end
  end

  // Lane extraction and extension of the word being read
  always_comb begin
    ld_b = mem_rd[{addr_q[1:0], 3'b000} +: 8];
    ld_h = addr_q[1] ? mem_rd[31:16] : mem_rd[15:0];
    case (size_q)
      2'b00:   load_val = {{24{sext_q & ld_b[7]}}, ld_b};
      2'b01:   load_val = {{16{sext_q & ld_h[15]}}, ld_h};
      default: load_val = mem_rd;
    endcase
  end

  // Read buffer and load result, both captured on the READ edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_q   <= '0;
      rdata_q <= '0;
    end else if (state_q == S_READ) begin
      buf_q <= mem_rd;
      if (!wr_q) rdata_q <= load_val;
    end
  end

  // Write data: full word, or buffered word with the addressed lane merged in
  always_comb begin
    mem_wd = '0;
    if (state_q == S_WRITE) begin
      if (size_q == 2'b10) begin
        mem_wd = wdata_q;
      end else begin
        mem_wd = buf_q;
        if (size_q == 2'b00) mem_wd[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
        else                 mem_wd[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
      end
    end
  end

  assign busy     = (state_q != S_IDLE);
  assign done     = (state_q == S_DONE);
  assign err      = done & err_q;
  assign mem_we   = (state_q == S_WRITE);
  assign mem_addr = {addr_q[31:2], 2'b00};
  assign rdata    = rdata_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: word memory attached to the DUT, byte-array
// reference model, directed scenarios followed by randomized accesses.
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req, wr, sign_ext;
  logic [1:0]  size;
  logic [31:0] addr, wdata;
  logic        busy, done, err, mem_we;
  logic [31:0] rdata, mem_addr, mem_wd, mem_rd;

  // memory attached to the DUT (64 words, aliased by address bits [7:2])
  logic [31:0] mem [64];
  logic        pl_en;
  logic [5:0]  pl_idx;
  logic [31:0] pl_val;
  int          we_count;
  logic [31:0] last_wd;

  // reference model: flat byte array, aliased by address bits [7:0]
  logic [7:0]  ref_bytes [256];
  logic [31:0] ref_rdata;

  int checks = 0;
  int fails  = 0;

  mem_access_ctrl dut (
    .clk(clk), .rst_n(rst_n), .req(req), .wr(wr), .size(size),
    .sign_ext(sign_ext), .addr(addr), .wdata(wdata), .busy(busy),
    .done(done), .err(err), .rdata(rdata), .mem_addr(mem_addr),
    .mem_wd(mem_wd), .mem_we(mem_we), .mem_rd(mem_rd)
  );

  always #5 clk = ~clk;

  assign mem_rd = mem[mem_addr[7:2]];

  // memory write port, plus preload path used while the DUT is in reset
  always @(posedge clk) begin
    if (pl_en)       mem[pl_idx] <= pl_val;
    else if (mem_we) mem[mem_addr[7:2]] <= mem_wd;
  end

  // write-cycle monitor
  always @(posedge clk) begin
    if (mem_we) begin
      we_count <= we_count + 1;
      last_wd  <= mem_wd;
    end
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_word(input logic [31:0] a);
    logic [7:0] b;
    b = {a[7:2], 2'b00};
    return {ref_bytes[b + 8'd3], ref_bytes[b + 8'd2], ref_bytes[b + 8'd1], ref_bytes[b]};
  endfunction

  // one complete access with latency, error, write and result checks
  task automatic access(input logic w, input logic [1:0] sz, input logic sx,
                        input logic [31:0] a, input logic [31:0] d);
    logic        e;
    int          lat, edges, we0, n;
    logic [31:0] v;
    logic [7:0]  bi;
    e   = (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00);
    lat = e ? 1 : (!w ? 2 : (sz == 2'b10 ? 2 : 3));
    @(negedge clk);
    req = 1'b1; wr = w; size = sz; sign_ext = sx; addr = a; wdata = d;
    we0 = we_count;
    @(posedge clk); #1;
    // garbage on the inputs while busy must have no effect
    req = 1'($urandom_range(0, 1)); wr = 1'($urandom_range(0, 1));
    size = 2'($urandom_range(0, 3)); sign_ext = 1'($urandom_range(0, 1));
    addr = $urandom; wdata = $urandom;
    edges = 1;
    while (done !== 1'b1 && edges < 6) begin
      @(posedge clk); #1;
      edges++;
    end
    req = 1'b0;
    chk("latency", 32'(edges), 32'(lat));
    chk("err", {31'd0, err}, {31'd0, e});
    if (!e) begin
      n = 1 << sz;
      if (w) begin
        for (int i = 0; i < n; i++) begin
          bi = a[7:0] + 8'(i);
          ref_bytes[bi] = d[8*i +: 8];
        end
      end else begin
        v = '0;
        for (int i = 0; i < n; i++) begin
          bi = a[7:0] + 8'(i);
          v = v | (32'(ref_bytes[bi]) << (8 * i));
        end
        if (sx && n == 1 && v[7])  v = v | 32'hFFFF_FF00;
        if (sx && n == 2 && v[15]) v = v | 32'hFFFF_0000;
        ref_rdata = v;
      end
    end
    chk("write_count", 32'(we_count - we0), (!e && w) ? 32'd1 : 32'd0);
    if (!e && w) chk("mem_wd", last_wd, ref_word(a));
    chk("rdata", rdata, ref_rdata);
    @(posedge clk); #1;
    chk("back_to_idle", {29'd0, busy, done, err}, 32'd0);
  endtask

  initial begin
    logic [31:0] a, w0;
    logic [1:0]  sz;
    int          pulses, edges;

    rst_n = 1'b0; req = 1'b0; wr = 1'b0; size = '0; sign_ext = 1'b0;
    addr = '0; wdata = '0; pl_en = 1'b0; pl_idx = '0; pl_val = '0;
    we_count = 0; last_wd = '0; ref_rdata = '0;

    #2;
    chk("reset_ctrl", {28'd0, busy, done, err, mem_we}, 32'd0);
    chk("reset_rdata", rdata, 32'd0);
    chk("reset_mem_addr", mem_addr, 32'd0);
    chk("reset_mem_wd", mem_wd, 32'd0);

    // preload memory and reference with the same random contents
    pl_en = 1'b1;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      pl_idx = 6'(i);
      pl_val = $urandom;
      for (int k = 0; k < 4; k++) ref_bytes[4 * i + k] = pl_val[8*k +: 8];
    end
    @(negedge clk);
    pl_en = 1'b0;
    rst_n = 1'b1;

    // word store then word load
    access(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF);
    access(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    chk("word_load_value", rdata, 32'hDEADBEEF);

    // byte store merge
    access(1'b1, 2'b10, 1'b0, 32'h10, 32'h11223344);
    access(1'b1, 2'b00, 1'b0, 32'h12, 32'h000000AA);
    chk("byte_store_merge", last_wd, 32'h11AA3344);

    // sign/zero-extended sub-word loads
    access(1'b1, 2'b10, 1'b0, 32'h20, 32'h8000F0FF);
    access(1'b0, 2'b00, 1'b1, 32'h20, 32'h0);
    chk("byte_load_sext", rdata, 32'hFFFFFFFF);
    access(1'b0, 2'b01, 1'b0, 32'h22, 32'h0);
    chk("half_load_zext", rdata, 32'h00008000);

    // misaligned and illegal accesses, each followed at once by a new request
    access(1'b0, 2'b10, 1'b0, 32'h13, 32'h0);
    access(1'b1, 2'b01, 1'b0, 32'h21, 32'h1234);
    access(1'b1, 2'b11, 1'b0, 32'h24, 32'h55);
    access(1'b0, 2'b10, 1'b0, 32'h20, 32'h0);

    // top-of-address-space word access
    access(1'b1, 2'b10, 1'b0, 32'hFFFFFFFC, 32'hCAFEF00D);
    access(1'b0, 2'b10, 1'b0, 32'hFFFFFFFC, 32'h0);

    // req held high across loads: one access per IDLE visit
    @(negedge clk);
    req = 1'b1; wr = 1'b0; size = 2'b10; sign_ext = 1'b0; addr = 32'h10;
    pulses = 0;
    for (int i = 0; i < 9; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1) pulses++;
    end
    req = 1'b0;
    ref_rdata = ref_word(32'h10);
    chk("held_req_done_pulses", 32'(pulses), 32'd3);
    chk("held_req_rdata", rdata, ref_rdata);
    chk("held_req_idle", {31'd0, busy}, 32'd0);

    // randomized accesses
    for (int t = 0; t < 80; t++) begin
      sz = 2'($urandom_range(0, 3));
      a  = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        if (sz == 2'b01) a[0] = 1'b0;
        if (sz == 2'b10) a[1:0] = 2'b00;
      end
      access(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom);
    end

    // reset asserted while a sub-word store is in WRITE
    a  = 32'h34;
    w0 = ref_word(a);
    @(negedge clk);
    req = 1'b1; wr = 1'b1; size = 2'b00; sign_ext = 1'b0; addr = a + 32'd1; wdata = 32'h5A;
    pulses = we_count;
    @(posedge clk); #1;
    req = 1'b0;
    edges = 1;
    while (mem_we !== 1'b1 && edges < 6) begin
      @(posedge clk); #1;
      edges++;
    end
    chk("reached_write", {31'd0, mem_we}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_mem_we_drop", {31'd0, mem_we}, 32'd0);
    chk("rst_ctrl", {29'd0, busy, done, err}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wd", mem_wd, 32'd0);
    @(posedge clk); #1;
    chk("rst_no_done", {31'd0, done}, 32'd0);
    chk("rst_no_write", 32'(we_count - pulses), 32'd0);
    chk("rst_word_intact", mem[a[7:2]], w0);
    @(negedge clk);
    rst_n = 1'b1;
    ref_rdata = '0;
    access(1'b0, 2'b10, 1'b0, a, 32'h0);

    // final memory image against the reference
    @(negedge clk);
    for (int i = 0; i < 64; i++) chk("final_mem", mem[i], ref_word(32'(4 * i)));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, fails);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  rising-edge clock (sole clock).
REQ-002 SHALL have ports: rst_n  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have ports: req  in  1  access request, sampled only in IDLE.
REQ-004 SHALL have ports: wr  in  1  1=store, 0=load.
REQ-005 SHALL have ports: size  in  2  00=byte, 01=halfword, 10=word, 11=illegal.
REQ-006 SHALL have ports: sign_ext  in  1  loads only: 1=sign-extend, 0=zero-extend.
REQ-007 SHALL have ports: addr  in  32  byte address.
REQ-008 SHALL have ports: wdata  in  32  store data, right-aligned for sub-word sizes.
REQ-009 SHALL have ports: busy  out  1  high in every state except IDLE.
REQ-010 SHALL have ports: done  out  1  one-cycle completion pulse.
REQ-011 SHALL have ports: err  out  1  valid with done; 1=misaligned or illegal size.
REQ-012 SHALL have ports: rdata  out  32  load result.
REQ-013 SHALL have ports: mem_addr  out  32  word-aligned byte address to memory.
REQ-014 SHALL have ports: mem_wd  out  32  write data to memory.
REQ-015 SHALL have ports: mem_we  out  1  memory write enable; memory writes on the rising edge.
REQ-016 SHALL have ports: mem_rd  in  32  memory read data, combinational from mem_addr.

Function
REQ-017 SHALL implement FSM states IDLE, READ, WRITE, DONE.
REQ-018 SHALL, in IDLE on a clock edge with req=1, latch addr, wdata, wr, size and sign_ext into internal registers; the latched copies alone drive later behaviour.
REQ-019 SHALL, from IDLE with req=1, transition as follows:
- misaligned access (halfword with addr[0]=1, word with addr[1:0]!=0, or size=11): DONE with err=1.
- load: READ.
- word store: WRITE.
- byte or halfword store: READ.
REQ-020 SHALL, in READ, capture mem_rd into an internal word buffer at the clock edge, then go to WRITE for sub-word stores and DONE for loads.
REQ-021 SHALL drive mem_we=1 only in WRITE, exactly one cycle, then go to DONE.
REQ-022 SHALL drive mem_addr={addr_q[31:2],2'b00} in all states.
REQ-023 SHALL use little-endian lanes: byte offset k selects bits [8k+7:8k]; halfword offset 0 selects [15:0], offset 2 selects [31:16].
REQ-024 SHALL drive mem_wd as follows in WRITE:
- word store: wdata_q.
- sub-word store: the buffered word with only the addressed lane(s) replaced by wdata_q[7:0] or wdata_q[15:0].
REQ-025 SHALL, for loads, load rdata at the READ edge with the selected lane, sign- or zero-extended to 32 bits; a word load passes the word unchanged.
REQ-026 SHALL hold rdata until the next completed load; stores and errored accesses leave rdata unchanged.
REQ-027 SHALL assert done for exactly the one DONE cycle, then return to IDLE; err is 0 in every cycle where done=0.
REQ-028 SHALL complete with the following latency, measured from the accepting edge to the cycle in which done=1 (edges counted):
- error: 1 edge.
- load: 2 edges.
- word store: 2 edges.
- sub-word store: 3 edges.
REQ-029 SHALL ignore req whenever busy=1; no queuing.
REQ-030 SHALL perform no memory write on an errored access.
REQ-031 SHALL accept a new req in the IDLE cycle immediately after DONE.
REQ-032 SHALL wrap addresses with no special handling; addr=32'hFFFFFFFC word access is legal.

Reset
REQ-033 SHALL, while rst_n=0, immediately force state=IDLE and busy=0, done=0, err=0, mem_we=0, rdata=0, mem_wd=0, mem_addr=0, and all latched registers to 0.
REQ-034 SHALL, on reset asserted mid-operation (including during WRITE), deassert mem_we asynchronously so that no partial or merged write occurs, and discard the access with no done pulse.

Verification
REQ-035 SHALL pass: word store addr=0x10, wdata=0xDEADBEEF, then word load addr=0x10 -> done 2 edges after each accept; rdata=0xDEADBEEF; err=0.
REQ-036 SHALL pass: memory word 0x10=0x11223344; byte store addr=0x12, wdata=0xAA -> one mem_we cycle with mem_wd=0x11AA3344; done 3 edges after accept.
REQ-037 SHALL pass: memory word 0x20=0x8000F0FF; byte load addr=0x20 with sign_ext=1 -> rdata=0xFFFFFFFF; halfword load addr=0x22 with sign_ext=0 -> rdata=0x00008000.
REQ-038 SHALL pass: word load addr=0x13 -> done+err 1 edge after accept; mem_we never asserted; rdata unchanged; next req accepted in the following IDLE cycle.
REQ-039 SHALL pass: rst_n pulsed low during WRITE of a sub-word store -> mem_we drops the same instant; target word unchanged; no done pulse; all outputs 0.
REQ-040 SHALL pass: req held high continuously across a load -> exactly one access per IDLE visit; req ignored while busy=1.
